// File: rtl/tube_pkg.sv
// Shared constants for the seven-segment scanner: digit count,
// active-low segment patterns (bit 6 = g ... bit 0 = a) and idle levels.
package tube_pkg;

  localparam int NDIG = 8;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // All cathodes off / all anodes off.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

endpackage

// File: rtl/tube_scan_hex2seg.sv
// Purely combinational hex digit to active-low seven-segment decoder.
module hex2seg
  import tube_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  // Table lookup of the glyph for one hex value.
  always_comb begin
    seg_o = SEG_OFF;
    case (val_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/tube_scan.sv
// Time-multiplexed 8-digit common-anode display driver. One digit per slot
// of DIV cycles, the first GAP cycles of each slot are blanked against
// ghosting. All display inputs are snapshotted once per frame so a frame
// never shows a mix of old and new values.
module tube_scan
  import tube_pkg::*;
#(
  parameter int DIV          = 100000,
  parameter int GAP          = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d7_i,
  input  logic [3:0] d6_i,
  input  logic [3:0] d5_i,
  input  logic [3:0] d4_i,
  input  logic [3:0] d3_i,
  input  logic [3:0] d2_i,
  input  logic [3:0] d1_i,
  input  logic [3:0] d0_i,
  input  logic [7:0] en_i,
  input  logic [7:0] blink_i,
  input  logic [7:0] dp_i,
  input  logic       blank_lz_i,
  output logic [7:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_n_o,
  output logic       frame_tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             slot_end, snap;

  logic [FRM_W-1:0] frm_q, frm_d;
  logic             phase_q, phase_d;

  logic [NDIG-1:0][3:0] d_in, d_s_q;
  logic [NDIG-1:0]      en_s_q, blink_s_q, dp_s_q;
  logic                 blank_lz_s_q;

  logic [NDIG-1:0] zero_from, vis;
  logic [3:0]      cur_val;
  logic [6:0]      cur_seg;

  logic [7:0] an_d;
  logic [6:0] seg_d;
  logic       dp_n_d, frame_tick_d;

  assign d_in = {d7_i, d6_i, d5_i, d4_i, d3_i, d2_i, d1_i, d0_i};

  assign slot_end = (cnt_q == CNT_LAST);
  assign snap     = slot_end && (idx_q == 3'd7);

  // Prescaler and digit index; idx wraps 7->0 by its 3-bit width.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Blink frame counter advances once per snapshot; phase flips on wrap.
  always_comb begin
    frm_d   = frm_q;
    phase_d = phase_q;
    if (snap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end
  end

  // Leading-zero run: zero_from[i] is set when digits i..7 are all zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      run          = run & (d_s_q[i] == 4'h0);
      zero_from[i] = run;
    end
  end

  // Per-digit visibility; digit 0 is exempt from leading-zero blanking.
  always_comb begin
    vis = '0;
    for (int i = 0; i < NDIG; i++) begin
      vis[i] = en_s_q[i] & ~(blink_s_q[i] & phase_q);
      if (i >= 1) begin
        vis[i] = vis[i] & ~(blank_lz_s_q & zero_from[i]);
      end
    end
  end

  assign cur_val = d_s_q[idx_q];

  hex2seg u_hex2seg (
    .val_i (cur_val),
    .seg_o (cur_seg)
  );

  // Next output values for the current slot position.
  always_comb begin
    an_d         = AN_OFF;
    seg_d        = SEG_OFF;
    dp_n_d       = 1'b1;
    frame_tick_d = snap;
    if ((cnt_q >= GAP_END) && vis[idx_q]) begin
      an_d   = ~(8'd1 << idx_q);
      seg_d  = cur_seg;
      dp_n_d = ~dp_s_q[idx_q];
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Frame snapshot of all display inputs plus blink state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_s_q        <= '0;
      en_s_q       <= '0;
      blink_s_q    <= '0;
      dp_s_q       <= '0;
      blank_lz_s_q <= 1'b0;
      frm_q        <= '0;
      phase_q      <= 1'b0;
    end else begin
      frm_q   <= frm_d;
      phase_q <= phase_d;
      if (snap) begin
        d_s_q        <= d_in;
        en_s_q       <= en_i;
        blink_s_q    <= blink_i;
        dp_s_q       <= dp_i;
        blank_lz_s_q <= blank_lz_i;
      end
    end
  end

  // Registered pin drivers; one cycle behind the scan position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_o         <= AN_OFF;
      seg_o        <= SEG_OFF;
      dp_n_o       <= 1'b1;
      frame_tick_o <= 1'b0;
    end else begin
      an_o         <= an_d;
      seg_o        <= seg_d;
      dp_n_o       <= dp_n_d;
      frame_tick_o <= frame_tick_d;
    end
  end

endmodule
